// File: rtl/scan_mux_seq_pkg.sv
// Shared types and helpers for the scanning N-to-1 multiplexer.
package scan_mux_seq_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Width of a binary index over n items, never narrower than one bit.
  function automatic int clog2_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scan_mux_seq_dwell_counter.sv
// Dwell counter: counts enabled cycles modulo DWELL and flags the last one.
module dwell_counter
  import scan_mux_seq_pkg::*;
#(
  parameter  int DWELL = 4,
  localparam int CNT_W = clog2_w(DWELL)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_end;

  assign w_at_end = (r_cnt == CNT_W'(DWELL - 1));
  assign o_tc     = i_en && w_at_end;

  // Clear wins over enable so a mode change always discards partial dwell.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_at_end) r_cnt <= '0;
      else          r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_mux_seq.sv
// Registered N-to-1 mux that either follows an external select or scans
// all channels, dwelling a fixed number of cycles on each.
module scan_mux_seq
  import scan_mux_seq_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 8,
  parameter  int DWELL    = 4,
  localparam int SEL_W    = clog2_w(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_in_data,
  input  logic                      i_mode,
  input  logic [SEL_W-1:0]          i_sel_in,
  input  logic                      i_hold,
  output logic [WIDTH-1:0]          o_out_data,
  output logic [SEL_W-1:0]          o_out_sel,
  output logic                      o_out_valid,
  output logic                      o_wrap,
  output logic                      o_sel_err
);

  mode_e            w_mode;
  logic             w_auto;
  logic             w_sel_oor;
  logic             w_last_ch;
  logic             w_cnt_en;
  logic             w_cnt_clr;
  logic             w_tc;
  logic [SEL_W-1:0] w_eff_sel;
  logic [WIDTH-1:0] w_mux;

  logic [SEL_W-1:0] r_ch;
  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_out_valid;
  logic             r_wrap;
  logic             r_sel_err;

  assign w_mode    = mode_e'(i_mode);
  assign w_auto    = (w_mode == MODE_AUTO);
  assign w_sel_oor = !w_auto && (32'(i_sel_in) >= 32'(CHANNELS));
  assign w_eff_sel = w_auto ? r_ch : i_sel_in;
  assign w_last_ch = (r_ch == SEL_W'(CHANNELS - 1));
  assign w_cnt_en  = w_auto && !i_hold;
  assign w_cnt_clr = !w_auto;

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_cnt_en),
    .i_clr   (w_cnt_clr),
    .o_tc    (w_tc)
  );

  // Decoded mux: a select past the last channel matches nothing and yields 0.
  always_comb begin
    w_mux = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_eff_sel == SEL_W'(k)) w_mux = i_in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ch <= '0;
    end else if (!w_auto) begin
      if (!w_sel_oor) r_ch <= i_sel_in;
    end else if (w_tc) begin
      r_ch <= w_last_ch ? '0 : r_ch + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_out_valid <= 1'b0;
      r_wrap      <= 1'b0;
      r_sel_err   <= 1'b0;
    end else begin
      r_out_data  <= w_mux;
      r_out_sel   <= w_eff_sel;
      r_out_valid <= 1'b1;
      r_wrap      <= w_tc && w_last_ch;
      r_sel_err   <= w_sel_oor;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_sel   = r_out_sel;
  assign o_out_valid = r_out_valid;
  assign o_wrap      = r_wrap;
  assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_scan_mux_seq.sv
// Directed scoreboard bench for scan_mux_seq (WIDTH=4, CHANNELS=6, DWELL=3).
module tb_scan_mux_seq;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 6;
  localparam int DWELL    = 3;
  localparam int SEL_W    = 3;

  logic                      clk;
  logic                      rst_n;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic                      mode;
  logic [SEL_W-1:0]          sel_in;
  logic                      hold;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      wrap;
  logic                      sel_err;

  scan_mux_seq #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_data   (in_data),
    .i_mode      (mode),
    .i_sel_in    (sel_in),
    .i_hold      (hold),
    .o_out_data  (out_data),
    .o_out_sel   (out_sel),
    .o_out_valid (out_valid),
    .o_wrap      (wrap),
    .o_sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] d;
    logic [2:0] s;
    logic       v;
    logic       w;
    logic       e;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   pat      = 0;

  // Hand-computed channel values: 4'hA^k, and a one-hot pattern 1<<(k%4).
  logic [3:0] DA [6] = '{4'hA, 4'hB, 4'h8, 4'h9, 4'hE, 4'hF};
  logic [3:0] OH [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};

  function automatic logic [23:0] build(input int p);
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < CHANNELS; k++)
      v[k*4 +: 4] = (p == 0) ? (4'hA ^ 4'(k)) : (4'b0001 << (k % 4));
    return v;
  endfunction

  // Apply one cycle of inputs and queue the output expected after the next edge.
  task automatic drive(input logic r, input logic m, input logic [2:0] s, input logic h,
                       input logic [3:0] ed, input logic [2:0] es, input logic ev,
                       input logic ew, input logic ee, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n   = r;
    mode    = m;
    sel_in  = s;
    hold    = h;
    in_data = build(pat);
    x.d = ed; x.s = es; x.v = ev; x.w = ew; x.e = ee; x.nm = nm;
    q.push_back(x);
  endtask

  // Monitor: samples just after each rising edge and checks against the queue.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (out_data !== x.d || out_sel !== x.s || out_valid !== x.v ||
            wrap !== x.w || sel_err !== x.e) begin
          failures++;
          $display("FAIL %s: got data=%h sel=%0d valid=%b wrap=%b err=%b, want data=%h sel=%0d valid=%b wrap=%b err=%b",
                   x.nm, out_data, out_sel, out_valid, wrap, sel_err,
                   x.d, x.s, x.v, x.w, x.e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel_in = '0; hold = 1'b0; in_data = build(0);

    // 1. Reset held three cycles, then first valid sample.
    repeat (3) drive(0, 0, 3'd0, 0, 4'h0, 3'd0, 0, 0, 0, "reset");
    drive(1, 0, 3'd0, 0, DA[0], 3'd0, 1, 0, 0, "release");

    // 2. MANUAL sweeps with two data patterns.
    for (int k = 0; k < CHANNELS; k++)
      drive(1, 0, 3'(k), 0, DA[k], 3'(k), 1, 0, 0, "man_sweep");
    pat = 1;
    for (int k = 0; k < CHANNELS; k++)
      drive(1, 0, 3'(k), 0, OH[k], 3'(k), 1, 0, 0, "man_onehot");
    pat = 0;

    // 3. Out-of-range selects; channel must stay at the last legal select.
    drive(1, 0, 3'd7, 0, 4'h0, 3'd7, 1, 0, 1, "sel7_err");
    drive(1, 0, 3'd2, 0, 4'h8, 3'd2, 1, 0, 0, "sel2_ok");
    drive(1, 0, 3'd6, 0, 4'h0, 3'd6, 1, 0, 1, "sel6_err");
    drive(1, 0, 3'd3, 0, DA[3], 3'd3, 1, 0, 0, "sel3_ok");
    drive(1, 0, 3'd7, 0, 4'h0, 3'd7, 1, 0, 1, "sel7_keep");
    drive(1, 1, 3'd7, 0, DA[3], 3'd3, 1, 0, 0, "auto_from3");
    drive(1, 1, 3'd7, 0, DA[3], 3'd3, 1, 0, 0, "auto_from3");
    drive(1, 1, 3'd7, 0, DA[3], 3'd3, 1, 0, 0, "auto_from3");
    drive(1, 1, 3'd7, 0, DA[4], 3'd4, 1, 0, 0, "auto_to4");

    // 4. AUTO from reset: full scan. wrap is registered on the edge ch leaves
    //    the last channel, so it accompanies the final channel-5 sample.
    drive(0, 1, 3'd7, 0, 4'h0, 3'd0, 0, 0, 0, "reset_auto");
    for (int k = 0; k < CHANNELS; k++)
      for (int d = 0; d < DWELL; d++)
        drive(1, 1, 3'd7, 0, DA[k], 3'(k), 1, (k == 5 && d == 2), 0, "auto_scan");
    drive(1, 1, 3'd7, 0, DA[0], 3'd0, 1, 0, 0, "auto_back0");
    drive(1, 1, 3'd7, 0, DA[0], 3'd0, 1, 0, 0, "auto_back0");

    // 5. Hold mid-dwell on channel 3; data keeps tracking the input.
    drive(0, 1, 3'd0, 0, 4'h0, 3'd0, 0, 0, 0, "reset_hold");
    for (int k = 0; k < 3; k++)
      for (int d = 0; d < DWELL; d++)
        drive(1, 1, 3'd0, 0, DA[k], 3'(k), 1, 0, 0, "pre_hold");
    drive(1, 1, 3'd0, 0, DA[3], 3'd3, 1, 0, 0, "pre_hold");
    drive(1, 1, 3'd0, 0, DA[3], 3'd3, 1, 0, 0, "pre_hold");
    pat = 1;
    repeat (5) drive(1, 1, 3'd0, 1, OH[3], 3'd3, 1, 0, 0, "hold3");
    pat = 0;
    drive(1, 1, 3'd0, 0, DA[3], 3'd3, 1, 0, 0, "unhold_last3");
    repeat (3) drive(1, 1, 3'd0, 0, DA[4], 3'd4, 1, 0, 0, "unhold_ch4");
    drive(1, 1, 3'd0, 0, DA[5], 3'd5, 1, 0, 0, "unhold_ch5");

    // 6. Mode switching and reset mid-scan.
    drive(1, 0, 3'd4, 0, DA[4], 3'd4, 1, 0, 0, "man4");
    repeat (3) drive(1, 1, 3'd0, 0, DA[4], 3'd4, 1, 0, 0, "auto_full4");
    drive(1, 1, 3'd0, 0, DA[5], 3'd5, 1, 0, 0, "auto_then5");
    drive(0, 1, 3'd0, 0, 4'h0, 3'd0, 0, 0, 0, "reset_on5");
    repeat (3) drive(1, 1, 3'd0, 0, DA[0], 3'd0, 1, 0, 0, "restart0");
    drive(1, 1, 3'd0, 0, DA[1], 3'd1, 1, 0, 0, "restart1");
    drive(1, 0, 3'd5, 0, DA[5], 3'd5, 1, 0, 0, "auto_to_man5");
    drive(1, 1, 3'd0, 0, DA[5], 3'd5, 1, 0, 0, "man5_auto");
    drive(1, 1, 3'd0, 0, DA[5], 3'd5, 1, 0, 0, "man5_auto");
    drive(1, 1, 3'd0, 0, DA[5], 3'd5, 1, 1, 0, "man5_wrap");
    drive(1, 1, 3'd0, 0, DA[0], 3'd0, 1, 0, 0, "after_wrap0");

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
